// File: rtl/fp16_result_sink_if.sv
// fp16_result_sink_if: FIFO push/pop, flush and status bundle for fp16_result_sink.
interface fp16_result_sink_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic             io_in_valid;
    logic [15:0]      io_in_bits;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [15:0]      io_out_bits;
    logic [2:0]       io_out_class;
    logic             io_clear;
    logic [CW-1:0]    io_count;
    logic             io_overflow;
    logic [CNT_W-1:0] io_stat_zero;
    logic [CNT_W-1:0] io_stat_inf;
    logic [CNT_W-1:0] io_stat_nan;
    logic [CNT_W-1:0] io_stat_sub;
    modport master (
        output io_in_valid, io_in_bits, io_out_ready, io_clear,
        input  io_out_valid, io_out_bits, io_out_class, io_count, io_overflow,
               io_stat_zero, io_stat_inf, io_stat_nan, io_stat_sub
    );
    modport slave (
        input  io_in_valid, io_in_bits, io_out_ready, io_clear,
        output io_out_valid, io_out_bits, io_out_class, io_count, io_overflow,
               io_stat_zero, io_stat_inf, io_stat_nan, io_stat_sub
    );
endinterface

// File: rtl/fp16_result_sink.sv
// fp16_result_sink: FIFO sink for FP16 products with head classification and sticky overflow.
// Class statistics counters are built only when FP16_SINK_STATS_EN is defined.
module fp16_result_sink #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic               clock,
    input logic               reset,
    fp16_result_sink_if.slave io
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, push;

    function automatic logic [2:0] fp_class(input logic [15:0] h);
        return h[14:10] == 5'd0  ? (h[9:0] == 10'd0 ? 3'd0 : 3'd1) :
               h[14:10] == 5'd31 ? (h[9:0] == 10'd0 ? 3'd3 : h[9] ? 3'd4 : 3'd5) : 3'd2;
    endfunction

    assign full = count_q == CW'(DEPTH);
    assign pop  = io.io_out_valid && io.io_out_ready;
    // Clear wins over everything, so a clear cycle never writes the array.
    assign push = io.io_in_valid && (!full || pop) && !io.io_clear;

    assign wr_d    = io.io_clear ? '0 : wr_q + AW'(push);
    assign rd_d    = io.io_clear ? '0 : rd_q + AW'(pop);
    assign count_d = io.io_clear ? '0 : count_q + CW'(push) - CW'(pop);
    assign ovf_d   = !io.io_clear && (ovf_q || (io.io_in_valid && full && !pop));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= io.io_in_bits;
    end

    assign io.io_out_valid = count_q != '0;
    assign io.io_out_bits  = io.io_out_valid ? mem_q[rd_q] : 16'h0000;
    assign io.io_out_class = fp_class(io.io_out_bits);
    assign io.io_count     = count_q;
    assign io.io_overflow  = ovf_q;

`ifdef FP16_SINK_STATS_EN
    logic [CNT_W-1:0] zero_q, inf_q, nan_q, sub_q;
    logic [2:0]       in_cls;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic hit);
        return (hit && c != '1) ? c + CNT_W'(1) : c;
    endfunction

    assign in_cls = fp_class(io.io_in_bits);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            zero_q <= '0;
            inf_q  <= '0;
            nan_q  <= '0;
            sub_q  <= '0;
        end else begin
            zero_q <= io.io_clear ? '0 : bump(zero_q, push && in_cls == 3'd0);
            sub_q  <= io.io_clear ? '0 : bump(sub_q,  push && in_cls == 3'd1);
            inf_q  <= io.io_clear ? '0 : bump(inf_q,  push && in_cls == 3'd3);
            nan_q  <= io.io_clear ? '0 : bump(nan_q,  push && in_cls[2]);
        end
    end

    assign io.io_stat_zero = zero_q;
    assign io.io_stat_inf  = inf_q;
    assign io.io_stat_nan  = nan_q;
    assign io.io_stat_sub  = sub_q;
`else
    assign io.io_stat_zero = '0;
    assign io.io_stat_inf  = '0;
    assign io.io_stat_nan  = '0;
    assign io.io_stat_sub  = '0;
`endif
endmodule
